// File: rtl/bcd_run_ctrl.sv
// bcd_run_ctrl: four-digit BCD run/pause/done counter controlled by start,
// stop and clear levels, advancing on single-cycle tick pulses.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset; overrides every other input
//   start_i        run request (level): IDLE->RUN, PAUSE->RUN
//   stop_i         pause request (level): RUN->PAUSE, blocks start
//   clear_i        return to IDLE with count 0000, from any state
//   tick_i         count-enable pulse; honoured only in RUN
//   count_o        packed BCD count, [3:0] units .. [15:12] thousands
//   state_o        IDLE=00 RUN=01 PAUSE=10 DONE=11
//   running_o      high iff state is RUN
//   digit_carry_o  bit i pulses when digit i rolls 9->0
//   done_o         one-cycle pulse on entry to DONE
//   wrap_o         one-cycle pulse when count rolls TERM->0000 (AUTO_STOP=0)
//
// Every output is a register. TERM must hold only decimal nibbles (0-9).
module bcd_run_ctrl #(
    parameter logic [15:0] TERM      = 16'h9999,
    parameter bit          AUTO_STOP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_i,
    input  logic        tick_i,
    output logic [15:0] count_o,
    output logic [1:0]  state_o,
    output logic        running_o,
    output logic [3:0]  digit_carry_o,
    output logic        done_o,
    output logic        wrap_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic [3:0]  carry_q;
    logic        done_q;
    logic        wrap_q;
    logic        running_q;

    // BCD +1 of the current count, with the set of digits that rolled 9->0.
    // A carry out of the thousands digit simply falls off the end.
    logic [15:0] count_inc_d;
    logic [3:0]  roll_d;
    logic [3:0]  nines_d;
    logic        c;

    always_comb begin
        count_inc_d = count_q;
        roll_d      = 4'b0000;
        nines_d     = 4'b0000;
        c           = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nines_d[i] = (count_q[4*i +: 4] == 4'd9);
            if (c) begin
                if (nines_d[i]) begin
                    count_inc_d[4*i +: 4] = 4'd0;
                    roll_d[i]             = 1'b1;
                end else begin
                    count_inc_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    c                     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= 16'h0000;
            carry_q   <= 4'b0000;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            // Pulses default low; only the tick paths below raise them.
            carry_q <= 4'b0000;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            if (clear_i) begin
                state_q   <= S_IDLE;
                count_q   <= 16'h0000;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_PAUSE: begin
                        if (!stop_i && start_i) begin
                            state_q   <= S_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // A stop wins over a coincident tick: that tick is lost.
                        if (stop_i) begin
                            state_q   <= S_PAUSE;
                            running_q <= 1'b0;
                        end else if (tick_i) begin
                            if (count_q == TERM) begin
                                if (AUTO_STOP) begin
                                    state_q   <= S_DONE;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end else begin
                                    // Digits sitting at 9 are the ones that roll to 0.
                                    count_q <= 16'h0000;
                                    wrap_q  <= 1'b1;
                                    carry_q <= nines_d;
                                end
                            end else begin
                                count_q <= count_inc_d;
                                carry_q <= roll_d;
                            end
                        end
                    end
                    default: ; // DONE: only clear or reset leave
                endcase
            end
        end
    end

    assign count_o       = count_q;
    assign state_o       = state_q;
    assign running_o     = running_q;
    assign digit_carry_o = carry_q;
    assign done_o        = done_q;
    assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
module tb_bcd_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, stop, clear, tick;

    // Three configurations share one input stream:
    //   0: TERM=9999 AUTO_STOP=1, 1: TERM=0012 AUTO_STOP=1, 2: TERM=9999 AUTO_STOP=0
    logic [15:0] cnt_w  [3];
    logic [1:0]  st_w   [3];
    logic        run_w  [3];
    logic [3:0]  dc_w   [3];
    logic        done_w [3];
    logic        wrap_w [3];

    bcd_run_ctrl #(.TERM(16'h9999), .AUTO_STOP(1'b1)) u_d0 (
        .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .clear_i(clear), .tick_i(tick),
        .count_o(cnt_w[0]), .state_o(st_w[0]), .running_o(run_w[0]),
        .digit_carry_o(dc_w[0]), .done_o(done_w[0]), .wrap_o(wrap_w[0]));
    bcd_run_ctrl #(.TERM(16'h0012), .AUTO_STOP(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .clear_i(clear), .tick_i(tick),
        .count_o(cnt_w[1]), .state_o(st_w[1]), .running_o(run_w[1]),
        .digit_carry_o(dc_w[1]), .done_o(done_w[1]), .wrap_o(wrap_w[1]));
    bcd_run_ctrl #(.TERM(16'h9999), .AUTO_STOP(1'b0)) u_d2 (
        .clk(clk), .reset(reset), .start_i(start), .stop_i(stop), .clear_i(clear), .tick_i(tick),
        .count_o(cnt_w[2]), .state_o(st_w[2]), .running_o(run_w[2]),
        .digit_carry_o(dc_w[2]), .done_o(done_w[2]), .wrap_o(wrap_w[2]));

    int checks = 0;
    int failures = 0;
    int done_seen1 = 0;

    // Reference model: count kept as a plain decimal integer.
    int m_term [3] = '{9999, 12, 9999};
    bit m_auto [3] = '{1'b1, 1'b1, 1'b0};
    int m_cnt  [3];
    int m_st   [3];   // 0 idle, 1 run, 2 pause, 3 done
    int m_dc   [3];
    bit m_done [3];
    bit m_wrap [3];

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Digit i rolls on a +1 exactly when v+1 is a multiple of 10^(i+1).
    function automatic int rolled(int v);
        int r = 0;
        int p = 10;
        for (int i = 0; i < 4; i++) begin
            if ((v + 1) % p == 0) r |= (1 << i);
            p *= 10;
        end
        return r;
    endfunction

    task automatic model_step(bit r, bit c, bit sp, bit st, bit tk);
        for (int d = 0; d < 3; d++) begin
            m_dc[d] = 0; m_done[d] = 0; m_wrap[d] = 0;
            if (r || c) begin
                m_cnt[d] = 0; m_st[d] = 0;
            end else if (m_st[d] == 0 || m_st[d] == 2) begin
                if (!sp && st) m_st[d] = 1;
            end else if (m_st[d] == 1) begin
                if (sp) m_st[d] = 2;
                else if (tk) begin
                    if (m_cnt[d] == m_term[d]) begin
                        if (m_auto[d]) begin
                            m_st[d] = 3; m_done[d] = 1;
                        end else begin
                            m_dc[d] = rolled(m_cnt[d]); m_cnt[d] = 0; m_wrap[d] = 1;
                        end
                    end else begin
                        m_dc[d] = rolled(m_cnt[d]); m_cnt[d] = m_cnt[d] + 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d.count", d), cnt_w[d], to_bcd(m_cnt[d]));
            chk($sformatf("d%0d.state", d), 16'(st_w[d]), 16'(m_st[d]));
            chk($sformatf("d%0d.running", d), 16'(run_w[d]), 16'(m_st[d] == 1));
            chk($sformatf("d%0d.carry", d), 16'(dc_w[d]), 16'(m_dc[d]));
            chk($sformatf("d%0d.done", d), 16'(done_w[d]), 16'(m_done[d]));
            chk($sformatf("d%0d.wrap", d), 16'(wrap_w[d]), 16'(m_wrap[d]));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare all outputs.
    task automatic step(bit r, bit c, bit sp, bit st, bit tk);
        reset = r; clear = c; stop = sp; start = st; tick = tk;
        @(posedge clk);
        #1;
        model_step(r, c, sp, st, tk);
        if (done_w[1]) done_seen1++;
        check_all();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0;
        #1;
        // Reset state
        step(1, 0, 0, 0, 0);
        chk("reset.count", cnt_w[0], 16'h0000);
        chk("reset.state", 16'(st_w[0]), 16'h0);

        // Start, 10 ticks -> 0010, units carry only on the 10th
        step(0, 0, 0, 1, 0);
        ticks(9);
        chk("t9.carry", 16'(dc_w[0]), 16'h0);
        step(0, 0, 0, 0, 1);
        chk("t10.count", cnt_w[0], 16'h0010);
        chk("t10.carry", 16'(dc_w[0]), 16'h1);
        chk("t10.running", 16'(run_w[0]), 16'h1);

        // TERM=0012 instance: 15 ticks total, halts at 0012 with a single done
        ticks(5);
        chk("term12.count", cnt_w[1], 16'h0012);
        chk("term12.state", 16'(st_w[1]), 16'h3);
        chk("term12.done_pulses", 16'(done_seen1), 16'h1);

        // 0099 -> 0100, 0999 -> 1000
        ticks(84);
        step(0, 0, 0, 0, 1);
        chk("c99.count", cnt_w[0], 16'h0100);
        chk("c99.carry", 16'(dc_w[0]), 16'h3);
        ticks(899);
        step(0, 0, 0, 0, 1);
        chk("c999.count", cnt_w[0], 16'h1000);
        chk("c999.carry", 16'(dc_w[0]), 16'h7);

        // Up to 9999, then the terminal tick: halt vs wrap
        ticks(8999);
        chk("pre.count", cnt_w[2], 16'h9999);
        step(0, 0, 0, 0, 1);
        chk("wrap.count", cnt_w[2], 16'h0000);
        chk("wrap.wrap", 16'(wrap_w[2]), 16'h1);
        chk("wrap.carry", 16'(dc_w[2]), 16'hF);
        chk("wrap.state", 16'(st_w[2]), 16'h1);
        chk("halt.state", 16'(st_w[0]), 16'h3);
        chk("halt.count", cnt_w[0], 16'h9999);
        ticks(2);
        chk("halt.hold", cnt_w[0], 16'h9999);

        // Stop + tick, resume, clear + start
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        ticks(5);
        step(0, 0, 1, 0, 1);
        chk("pause.state", 16'(st_w[0]), 16'h2);
        chk("pause.count", cnt_w[0], 16'h0005);
        step(0, 0, 0, 1, 1);
        chk("resume.state", 16'(st_w[0]), 16'h1);
        chk("resume.count", cnt_w[0], 16'h0005);
        step(0, 1, 0, 1, 0);
        chk("clr.state", 16'(st_w[0]), 16'h0);
        chk("clr.count", cnt_w[0], 16'h0000);

        // Reset mid-run discards a coincident tick
        step(0, 0, 0, 1, 0);
        ticks(3);
        step(1, 0, 0, 0, 1);
        chk("rst.count", cnt_w[0], 16'h0000);
        chk("rst.state", 16'(st_w[0]), 16'h0);
        chk("rst.pulses", {11'd0, dc_w[0], done_w[0]}, 16'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(63) == 0, $urandom_range(31) == 0,
                 $urandom_range(7) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_run_ctrl.md
BCD_RUN_CTRL -- requirements
Module: bcd_run_ctrl

Interface
REQ-001 Parameter TERM, 16'h9999, terminal count as 4 packed BCD digits; every nibble SHALL be 0-9.
REQ-002 Parameter AUTO_STOP, 1, 1 = halt at TERM; 0 = wrap to 0000 after TERM.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level, sampled each edge; request to run.
REQ-006 stop  input  1  level; request to pause.
REQ-007 clear  input  1  level; return to IDLE and zero the count.
REQ-008 tick  input  1  single-cycle count-enable pulse from an external prescaler.
REQ-009 count  output  16  four BCD digits; [3:0] is units, [15:12] is thousands.
REQ-010 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-011 running  output  1  high iff state==RUN.
REQ-012 digit_carry  output  4  bit i is high for one cycle when digit i rolls 9->0.
REQ-013 done  output  1  one-cycle pulse on entry to DONE.
REQ-014 wrap  output  1  one-cycle pulse when count goes from TERM to 0000 (AUTO_STOP=0 only).

Function
REQ-015 All outputs SHALL be registered; effects of inputs sampled at edge N SHALL be visible after edge N.
REQ-016 Input priority in every state SHALL be: clear > stop > start > tick.
REQ-017 Clear in any state SHALL force count=0000, state=IDLE, and all pulse outputs to 0.
REQ-018 IDLE: start (no stop, no clear) -> RUN; count held; tick ignored.
REQ-019 RUN: stop -> PAUSE with count held; a tick in the same cycle SHALL NOT be counted.
REQ-020 RUN: tick with count != TERM -> count increments by 1 in BCD; state unchanged.
REQ-021 BCD increment: units +1; a digit at 9 SHALL become 0 and carry into the next digit; a carry out of thousands SHALL be discarded.
REQ-022 digit_carry[i] SHALL assert exactly for the increments on which digit i rolled 9->0.
REQ-023 RUN: tick with count==TERM and AUTO_STOP=1 -> state=DONE, count held at TERM, done=1 for one cycle, no digit_carry.
REQ-024 RUN: tick with count==TERM and AUTO_STOP=0 -> count=0000, wrap=1 for one cycle, state stays RUN; digit_carry SHALL report the rolled digits.
REQ-025 PAUSE: start without stop -> RUN; count held; tick ignored.
REQ-026 DONE: start, stop, and tick SHALL be ignored; only clear or reset leaves DONE.
REQ-027 start held high continuously SHALL NOT cause any transition beyond the one in REQ-018/025.
REQ-028 Pulse outputs (done, wrap, digit_carry) SHALL be 0 on every cycle not named in REQ-022/023/024.
REQ-029 count SHALL never hold a non-BCD nibble.

Reset
REQ-030 reset SHALL override all inputs, including clear.
REQ-031 reset SHALL set count=0000, state=IDLE, running=0, done=0, wrap=0, and digit_carry=0000.
REQ-032 reset asserted mid-RUN SHALL discard any tick sampled in the same cycle.

Verification
REQ-033 Reset, start, 10 ticks -> count=0010; digit_carry=0001 on the 10th tick only; running=1.
REQ-034 From count=0099, one tick -> count=0100 and digit_carry=0011; from 0999, one tick -> 1000 and digit_carry=0111.
REQ-035 TERM=0012 and AUTO_STOP=1, run 12 ticks then 3 more -> count stays 0012, state=11, done pulses once.
REQ-036 AUTO_STOP=0 with default TERM, preload to 9999 by ticking, one tick -> count=0000, wrap=1, digit_carry=1111, state=01.
REQ-037 In RUN at count=0005, stop and tick in the same cycle -> state=10, count=0005; then start -> state=01; then clear and start together -> state=00, count=0000.
REQ-038 Mid-RUN, reset and tick together -> count=0000, state=00, all pulse outputs 0.
